fwd_hazard_unit: RTL and testbench
==================================

// Module: fwd_hazard_unit
// PURPOSE
//  Parametrised forwarding + load-use hazard unit for the pipelined core. Evaluates the
//  instruction in ID against every in-flight producer, registers the forward-mux selects
//  so they are stable at the start of EX, and drives a counted stall for multi-cycle
//  load latency. Generalises 2-source/2-port forwarding to N sources, M read ports.
// PARAMETERS
//  REG_AW    5  register address width
//  NUM_RS    2  read ports per instruction (rs1, rs2, ...)
//  NUM_STG   3  forward sources after EX; stage 0 = EX/MEM (youngest), NUM_STG-1 oldest
//  LOAD_STG  1  first stage index at which load data is forwardable (1 = MEM/WB)
//  SEL_W     $clog2(NUM_STG+1)  width of one select field
// PORTS
//  clk_i            in   1               clock, rising edge
//  rst_i            in   1               async reset, active-low
//  id_rs_i          in   NUM_RS*REG_AW   source regs of ID instr, port p at [p*REG_AW +: REG_AW]
//  id_rs_used_i     in   NUM_RS          port p actually reads a register
//  idexe_rd_i       in   REG_AW          dest of instr in EX
//  idexe_regwrite_i in   1               EX instr writes RF
//  idexe_memread_i  in   1               EX instr is a load
//  stg_rd_i         in   NUM_STG*REG_AW  dest per post-EX stage
//  stg_regwrite_i   in   NUM_STG         write enable per stage
//  stg_memread_i    in   NUM_STG         stage holds a load
//  flush_i          in   1               branch/exception flush of ID and EX
//  fwd_sel_o        out  NUM_RS*SEL_W    registered select for EX operand mux per port
//  stall_o          out  1               hold PC and IF/ID, insert bubble into ID/EX
// BEHAVIOUR
//  - Reset (rst_i low, async): fwd_sel_o=0 all ports, state IDLE, counter 0, stall_o=0.
//  - Next-cycle view: producer in EX becomes stage 0; stage k becomes stage k+1. Candidate
//    j=0 is idexe_*, candidate j=k (1..NUM_STG-1) is stg_*[k-1]; stg[NUM_STG-1] retires
//    to RF (write-before-read RF), not a candidate.
//  - Match for port p, candidate j: id_rs_used_i[p] & we_j & rd_j!=0 & rd_j==rs_p.
//    Youngest (lowest j) match wins. Select encoding: 0 = RF, j+1 = stage j.
//  - Load-use: if winning candidate j is a load and j<LOAD_STG, need=LOAD_STG-j stall cycles.
//    Need = max over ports.
//  - FSM: IDLE: need>0 -> stall_o=1 (combinational, same cycle), cnt<=need-1, go STALL if
//    need>1 else remain IDLE; fwd_sel_o<=0 (bubble enters EX). need==0 -> fwd_sel_o<=sel.
//    STALL: stall_o=1, fwd_sel_o<=0, cnt<=cnt-1; cnt==1 -> IDLE. Compares ignored in STALL.
//  - Select registered every cycle stall_o=0; latency 1 cycle (ID compute -> EX use).
//  - flush_i (highest priority, sync): next state IDLE, cnt<=0, fwd_sel_o<=0; stall_o forced
//    0 in flush cycle.
//  - Reset mid-stall returns to IDLE immediately, stall_o drops asynchronously.
//  - rd==0 never forwards or stalls; unused ports yield select 0 and no stall.
// STRUCTURE
//  - fwd_pkg: FWD_SEL_RF=0 constant, sel field width function, state enum {IDLE,STALL}.
//  - Sub-module fwd_match_prio: one port's youngest-first matcher over NUM_STG candidates,
//    outputs sel and load-need; instantiated NUM_RS times via generate. Top holds FSM,
//    counter ($clog2(LOAD_STG+1) bits) and select registers.
// TESTING (defaults unless stated)
//  - rs1=5, EX rd=5 we=1 non-load -> next cycle fwd_sel[0]=1, stall_o=0 throughout.
//  - rs2=7, EX rd=7 and stage0 rd=7 both we -> fwd_sel[1]=1 (youngest wins), not 2.
//  - rs1=3, EX load rd=3 -> stall_o=1 one cycle, fwd_sel=0; next cycle (load now stage 0,
//    same inputs shifted) -> fwd_sel[0]=2, stall_o=0.
//  - LOAD_STG=2, EX load rd=4, rs2=4 -> stall_o high exactly 2 cycles, then fwd_sel[1]=3.
//  - rs1=0 with EX rd=0 we=1 -> sel 0, no stall; id_rs_used_i=0 with match -> sel 0.
//  - flush_i during LOAD_STG=2 stall, and rst_i low mid-stall -> stall_o=0, fwd_sel_o=0 at once.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding / load-use hazard unit.
package fwd_pkg;

    localparam int FWD_SEL_RF = 0;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        STALL = 1'b1
    } fwd_state_e;

    // One select field encodes "register file" plus one code per forward stage.
    function automatic int sel_width(input int num_stg);
        return $clog2(num_stg + 1);
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage operands, in-flight producer descriptors and the resulting forward/stall controls.
interface fwd_hazard_unit_if #(
    parameter int REG_AW  = 5,
    parameter int NUM_RS  = 2,
    parameter int NUM_STG = 3,
    parameter int SEL_W   = 2
);
    logic [NUM_RS*REG_AW-1:0]  id_rs_i;
    logic [NUM_RS-1:0]         id_rs_used_i;
    logic [REG_AW-1:0]         idexe_rd_i;
    logic                      idexe_regwrite_i;
    logic                      idexe_memread_i;
    logic [NUM_STG*REG_AW-1:0] stg_rd_i;
    logic [NUM_STG-1:0]        stg_regwrite_i;
    logic [NUM_STG-1:0]        stg_memread_i;
    logic                      flush_i;
    logic [NUM_RS*SEL_W-1:0]   fwd_sel_o;
    logic                      stall_o;

    modport master (
        output id_rs_i, id_rs_used_i, idexe_rd_i, idexe_regwrite_i, idexe_memread_i,
               stg_rd_i, stg_regwrite_i, stg_memread_i, flush_i,
        input  fwd_sel_o, stall_o
    );

    modport slave (
        input  id_rs_i, id_rs_used_i, idexe_rd_i, idexe_regwrite_i, idexe_memread_i,
               stg_rd_i, stg_regwrite_i, stg_memread_i, flush_i,
        output fwd_sel_o, stall_o
    );
endinterface

// File: rtl/fwd_match_prio.sv
// Youngest-first producer match for one read port; yields the forward select and
// the number of load-latency stall cycles that match implies.
module fwd_match_prio
    import fwd_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int NUM_STG  = 3,
    parameter int LOAD_STG = 1,
    parameter int SEL_W    = 2,
    parameter int CNT_W    = 1
) (
    input  logic [REG_AW-1:0]         rs,
    input  logic                      rs_used,
    input  logic [NUM_STG*REG_AW-1:0] cand_rd,
    input  logic [NUM_STG-1:0]        cand_we,
    input  logic [NUM_STG-1:0]        cand_ld,
    output logic [SEL_W-1:0]          sel,
    output logic [CNT_W-1:0]          need
);

    logic hit_s;

    // Walk oldest to youngest so the youngest hit overwrites the others.
    always_comb begin
        sel   = SEL_W'(FWD_SEL_RF);
        need  = '0;
        hit_s = 1'b0;
        for (int j = NUM_STG - 1; j >= 0; j--) begin
            hit_s = rs_used && cand_we[j] && (cand_rd[j*REG_AW +: REG_AW] != '0)
                    && (cand_rd[j*REG_AW +: REG_AW] == rs);
            sel   = hit_s ? SEL_W'(j + 1) : sel;
            need  = (hit_s && cand_ld[j] && (j < LOAD_STG)) ? CNT_W'(LOAD_STG - j)
                  : (hit_s ? '0 : need);
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select generation for N read ports over M post-EX producers, with a
// counted stall for loads whose data is not yet forwardable.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int NUM_RS   = 2,
    parameter int NUM_STG  = 3,
    parameter int LOAD_STG = 1,
    parameter int SEL_W    = sel_width(NUM_STG)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    fwd_hazard_unit_if.slave bus
);

    localparam int CNT_W = $clog2(LOAD_STG + 1);

    logic [NUM_STG*REG_AW-1:0] cand_rd_s;
    logic [NUM_STG-1:0]        cand_we_s;
    logic [NUM_STG-1:0]        cand_ld_s;
    logic [NUM_RS*SEL_W-1:0]   sel_s;
    logic [CNT_W-1:0]          need_s [NUM_RS];
    logic [CNT_W-1:0]          need_max_s;
    logic                      stall_s;
    logic                      unused_s;

    fwd_state_e                state_r;
    logic [CNT_W-1:0]          cnt_r;
    logic [NUM_RS*SEL_W-1:0]   fwd_sel_r;

    // Candidates as they will sit next cycle: EX becomes stage 0, stage k becomes k+1.
    assign cand_rd_s[REG_AW-1:0] = bus.idexe_rd_i;
    assign cand_we_s[0]          = bus.idexe_regwrite_i;
    assign cand_ld_s[0]          = bus.idexe_memread_i;

    for (genvar k = 1; k < NUM_STG; k++) begin : g_cand
        assign cand_rd_s[k*REG_AW +: REG_AW] = bus.stg_rd_i[(k-1)*REG_AW +: REG_AW];
        assign cand_we_s[k]                  = bus.stg_regwrite_i[k-1];
        assign cand_ld_s[k]                  = bus.stg_memread_i[k-1];
    end

    // The oldest stage retires into a write-before-read register file.
    assign unused_s = ^{bus.stg_rd_i[NUM_STG*REG_AW-1 -: REG_AW],
                        bus.stg_regwrite_i[NUM_STG-1], bus.stg_memread_i[NUM_STG-1]};

    for (genvar p = 0; p < NUM_RS; p++) begin : g_port
        fwd_match_prio #(
            .REG_AW   (REG_AW),
            .NUM_STG  (NUM_STG),
            .LOAD_STG (LOAD_STG),
            .SEL_W    (SEL_W),
            .CNT_W    (CNT_W)
        ) u_match (
            .rs      (bus.id_rs_i[p*REG_AW +: REG_AW]),
            .rs_used (bus.id_rs_used_i[p]),
            .cand_rd (cand_rd_s),
            .cand_we (cand_we_s),
            .cand_ld (cand_ld_s),
            .sel     (sel_s[p*SEL_W +: SEL_W]),
            .need    (need_s[p])
        );
    end

    // Worst-case load latency across all read ports.
    always_comb begin
        need_max_s = '0;
        for (int p = 0; p < NUM_RS; p++) begin
            need_max_s = (need_s[p] > need_max_s) ? need_s[p] : need_max_s;
        end
    end

    // Stall is raised in the detecting cycle itself; reset and flush both kill it at once.
    always_comb begin
        stall_s = 1'b0;
        if (!rst_i || bus.flush_i) begin
            stall_s = 1'b0;
        end else if (state_r == STALL) begin
            stall_s = 1'b1;
        end else begin
            stall_s = (need_max_s != '0);
        end
    end

    // Stall sequencer and registered forward selects (bubble selects RF).
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            fwd_sel_r <= '0;
        end else if (bus.flush_i) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            fwd_sel_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (need_max_s != '0) begin
                        fwd_sel_r <= '0;
                        cnt_r     <= need_max_s - CNT_W'(1);
                        state_r   <= (need_max_s != CNT_W'(1)) ? STALL : IDLE;
                    end else begin
                        fwd_sel_r <= sel_s;
                        cnt_r     <= '0;
                        state_r   <= IDLE;
                    end
                end
                STALL: begin
                    fwd_sel_r <= '0;
                    cnt_r     <= (cnt_r != '0) ? cnt_r - CNT_W'(1) : '0;
                    state_r   <= ((cnt_r == CNT_W'(1)) || (cnt_r == '0)) ? IDLE : STALL;
                end
                default: begin
                    state_r   <= IDLE;
                    cnt_r     <= '0;
                    fwd_sel_r <= '0;
                end
            endcase
        end
    end

    assign bus.fwd_sel_o = fwd_sel_r;
    assign bus.stall_o   = stall_s;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: one instance with single-cycle load latency, one with two.
module tb_fwd_hazard_unit;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    typedef struct {
        int         dut;
        logic [3:0] sel;
        string      tag;
    } exp_t;

    exp_t sb_q[$];

    fwd_hazard_unit_if #(.REG_AW(5), .NUM_RS(2), .NUM_STG(3), .SEL_W(2)) ifa ();
    fwd_hazard_unit_if #(.REG_AW(5), .NUM_RS(2), .NUM_STG(3), .SEL_W(2)) ifb ();

    fwd_hazard_unit #(.REG_AW(5), .NUM_RS(2), .NUM_STG(3), .LOAD_STG(1)) u_a (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (ifa)
    );

    fwd_hazard_unit #(.REG_AW(5), .NUM_RS(2), .NUM_STG(3), .LOAD_STG(2)) u_b (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (ifb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic clear_inputs();
        ifa.id_rs_i = '0; ifa.id_rs_used_i = '0; ifa.idexe_rd_i = '0;
        ifa.idexe_regwrite_i = 1'b0; ifa.idexe_memread_i = 1'b0; ifa.stg_rd_i = '0;
        ifa.stg_regwrite_i = '0; ifa.stg_memread_i = '0; ifa.flush_i = 1'b0;
        ifb.id_rs_i = '0; ifb.id_rs_used_i = '0; ifb.idexe_rd_i = '0;
        ifb.idexe_regwrite_i = 1'b0; ifb.idexe_memread_i = 1'b0; ifb.stg_rd_i = '0;
        ifb.stg_regwrite_i = '0; ifb.stg_memread_i = '0; ifb.flush_i = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        // A pending load-use during reset must not raise stall.
        ifb.id_rs_i = {5'd0, 5'd4}; ifb.id_rs_used_i = 2'b01;
        ifb.idexe_rd_i = 5'd4; ifb.idexe_regwrite_i = 1'b1; ifb.idexe_memread_i = 1'b1;
        #3;
        checks++; if (ifa.fwd_sel_o !== 4'b0000) begin errors++; $display("FAIL reset_sel_a: got %b want 0000", ifa.fwd_sel_o); end
        checks++; if (ifa.stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall_a: got %b want 0", ifa.stall_o); end
        checks++; if (ifb.fwd_sel_o !== 4'b0000) begin errors++; $display("FAIL reset_sel_b: got %b want 0000", ifb.fwd_sel_o); end
        checks++; if (ifb.stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall_b: got %b want 0", ifb.stall_o); end
        tick();
        clear_inputs();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fwd_ex();
        exp_t e;
        logic [3:0] got;
        for (int s = 0; s < 2; s++) begin
            clear_inputs();
            if (s == 0) begin
                ifa.id_rs_i = {5'd0, 5'd5}; ifa.id_rs_used_i = 2'b01;
                ifa.idexe_rd_i = 5'd5; ifa.idexe_regwrite_i = 1'b1;
                sb_q.push_back('{0, 4'b0001, "fwd_ex"});
            end else begin
                sb_q.push_back('{0, 4'b0000, "fwd_ex_idle"});
            end
            #3;
            checks++; if (ifa.stall_o !== 1'b0) begin errors++; $display("FAIL fwd_ex_stall[%0d]: got %b want 0", s, ifa.stall_o); end
            tick();
            e = sb_q.pop_front();
            got = ifa.fwd_sel_o;
            checks++; if (got !== e.sel) begin errors++; $display("FAIL %s: fwd_sel=%b want %b", e.tag, got, e.sel); end
        end
    endtask

    task automatic test_youngest();
        exp_t e;
        logic [3:0] got;
        for (int s = 0; s < 3; s++) begin
            clear_inputs();
            case (s)
                0: begin
                    ifa.id_rs_i = {5'd7, 5'd0}; ifa.id_rs_used_i = 2'b10;
                    ifa.idexe_rd_i = 5'd7; ifa.idexe_regwrite_i = 1'b1;
                    ifa.stg_rd_i = {5'd0, 5'd0, 5'd7}; ifa.stg_regwrite_i = 3'b001;
                    sb_q.push_back('{0, 4'b0100, "youngest_ex_over_s0"});
                end
                1: begin
                    ifa.id_rs_i = {5'd7, 5'd9}; ifa.id_rs_used_i = 2'b11;
                    ifa.stg_rd_i = {5'd0, 5'd9, 5'd7}; ifa.stg_regwrite_i = 3'b011;
                    sb_q.push_back('{0, 4'b1011, "older_stages"});
                end
                default: begin
                    ifa.id_rs_i = {5'd0, 5'd11}; ifa.id_rs_used_i = 2'b01;
                    ifa.stg_rd_i = {5'd11, 5'd11, 5'd0}; ifa.stg_regwrite_i = 3'b100;
                    sb_q.push_back('{0, 4'b0000, "retiring_not_cand"});
                end
            endcase
            #3;
            checks++; if (ifa.stall_o !== 1'b0) begin errors++; $display("FAIL youngest_stall[%0d]: got %b want 0", s, ifa.stall_o); end
            tick();
            e = sb_q.pop_front();
            got = ifa.fwd_sel_o;
            checks++; if (got !== e.sel) begin errors++; $display("FAIL %s: fwd_sel=%b want %b", e.tag, got, e.sel); end
        end
    endtask

    task automatic test_load_use();
        exp_t e;
        logic [3:0] got;
        logic exp_st;
        for (int s = 0; s < 3; s++) begin
            clear_inputs();
            case (s)
                0: begin
                    ifa.id_rs_i = {5'd0, 5'd3}; ifa.id_rs_used_i = 2'b01;
                    ifa.idexe_rd_i = 5'd3; ifa.idexe_regwrite_i = 1'b1; ifa.idexe_memread_i = 1'b1;
                    exp_st = 1'b1; sb_q.push_back('{0, 4'b0000, "load_bubble"});
                end
                1: begin
                    ifa.id_rs_i = {5'd0, 5'd3}; ifa.id_rs_used_i = 2'b01;
                    ifa.stg_rd_i = {5'd0, 5'd0, 5'd3}; ifa.stg_regwrite_i = 3'b001; ifa.stg_memread_i = 3'b001;
                    exp_st = 1'b0; sb_q.push_back('{0, 4'b0010, "load_fwd_s0"});
                end
                default: begin
                    ifa.id_rs_i = {5'd8, 5'd0}; ifa.id_rs_used_i = 2'b10;
                    ifa.idexe_rd_i = 5'd8; ifa.idexe_regwrite_i = 1'b1;
                    ifa.stg_rd_i = {5'd0, 5'd0, 5'd8}; ifa.stg_regwrite_i = 3'b001; ifa.stg_memread_i = 3'b001;
                    exp_st = 1'b0; sb_q.push_back('{0, 4'b0100, "alu_shadows_load"});
                end
            endcase
            #3;
            checks++; if (ifa.stall_o !== exp_st) begin errors++; $display("FAIL load_use_stall[%0d]: got %b want %b", s, ifa.stall_o, exp_st); end
            tick();
            e = sb_q.pop_front();
            got = ifa.fwd_sel_o;
            checks++; if (got !== e.sel) begin errors++; $display("FAIL %s: fwd_sel=%b want %b", e.tag, got, e.sel); end
        end
    endtask

    task automatic test_load_two_cycle();
        exp_t e;
        logic [3:0] got;
        logic exp_st;
        for (int s = 0; s < 6; s++) begin
            clear_inputs();
            case (s)
                0: begin
                    ifb.id_rs_i = {5'd4, 5'd0}; ifb.id_rs_used_i = 2'b10;
                    ifb.idexe_rd_i = 5'd4; ifb.idexe_regwrite_i = 1'b1; ifb.idexe_memread_i = 1'b1;
                    exp_st = 1'b1; sb_q.push_back('{1, 4'b0000, "ld2_c0"});
                end
                1: begin
                    ifb.id_rs_i = {5'd4, 5'd0}; ifb.id_rs_used_i = 2'b10;
                    ifb.stg_rd_i = {5'd0, 5'd0, 5'd4}; ifb.stg_regwrite_i = 3'b001; ifb.stg_memread_i = 3'b001;
                    exp_st = 1'b1; sb_q.push_back('{1, 4'b0000, "ld2_c1"});
                end
                2: begin
                    ifb.id_rs_i = {5'd4, 5'd0}; ifb.id_rs_used_i = 2'b10;
                    ifb.stg_rd_i = {5'd0, 5'd4, 5'd0}; ifb.stg_regwrite_i = 3'b010; ifb.stg_memread_i = 3'b010;
                    exp_st = 1'b0; sb_q.push_back('{1, 4'b1100, "ld2_fwd_s1"});
                end
                3: begin
                    ifb.id_rs_i = {5'd0, 5'd6}; ifb.id_rs_used_i = 2'b01;
                    ifb.stg_rd_i = {5'd0, 5'd0, 5'd6}; ifb.stg_regwrite_i = 3'b001; ifb.stg_memread_i = 3'b001;
                    exp_st = 1'b1; sb_q.push_back('{1, 4'b0000, "ld1_in_b"});
                end
                4: begin
                    ifb.id_rs_i = {5'd0, 5'd6}; ifb.id_rs_used_i = 2'b01;
                    ifb.stg_rd_i = {5'd0, 5'd6, 5'd0}; ifb.stg_regwrite_i = 3'b010; ifb.stg_memread_i = 3'b010;
                    exp_st = 1'b0; sb_q.push_back('{1, 4'b0011, "ld1_fwd_s1"});
                end
                default: begin
                    exp_st = 1'b0; sb_q.push_back('{1, 4'b0000, "ld2_quiet"});
                end
            endcase
            #3;
            checks++; if (ifb.stall_o !== exp_st) begin errors++; $display("FAIL ld2_stall[%0d]: got %b want %b", s, ifb.stall_o, exp_st); end
            tick();
            e = sb_q.pop_front();
            got = ifb.fwd_sel_o;
            checks++; if (got !== e.sel) begin errors++; $display("FAIL %s: fwd_sel=%b want %b", e.tag, got, e.sel); end
        end
    endtask

    task automatic test_zero_unused();
        exp_t e;
        logic [3:0] got;
        for (int s = 0; s < 4; s++) begin
            clear_inputs();
            ifa.idexe_regwrite_i = 1'b1;
            case (s)
                0: begin
                    ifa.id_rs_used_i = 2'b01;
                    sb_q.push_back('{0, 4'b0000, "rd0_alu"});
                end
                1: begin
                    ifa.id_rs_used_i = 2'b01; ifa.idexe_memread_i = 1'b1;
                    sb_q.push_back('{0, 4'b0000, "rd0_load"});
                end
                2: begin
                    ifa.id_rs_i = {5'd0, 5'd5}; ifa.idexe_rd_i = 5'd5; ifa.idexe_memread_i = 1'b1;
                    sb_q.push_back('{0, 4'b0000, "unused_port_load"});
                end
                default: begin
                    ifa.id_rs_i = {5'd5, 5'd5}; ifa.id_rs_used_i = 2'b01; ifa.idexe_rd_i = 5'd5;
                    sb_q.push_back('{0, 4'b0001, "one_port_used"});
                end
            endcase
            #3;
            checks++; if (ifa.stall_o !== 1'b0) begin errors++; $display("FAIL zero_unused_stall[%0d]: got %b want 0", s, ifa.stall_o); end
            tick();
            e = sb_q.pop_front();
            got = ifa.fwd_sel_o;
            checks++; if (got !== e.sel) begin errors++; $display("FAIL %s: fwd_sel=%b want %b", e.tag, got, e.sel); end
        end
    endtask

    task automatic test_flush();
        exp_t e;
        logic [3:0] got;
        logic exp_st;
        logic got_st;
        int dut;
        for (int s = 0; s < 4; s++) begin
            clear_inputs();
            dut = (s == 3) ? 0 : 1;
            case (s)
                0: begin
                    ifb.id_rs_i = {5'd4, 5'd0}; ifb.id_rs_used_i = 2'b10;
                    ifb.idexe_rd_i = 5'd4; ifb.idexe_regwrite_i = 1'b1; ifb.idexe_memread_i = 1'b1;
                    exp_st = 1'b1; sb_q.push_back('{1, 4'b0000, "flush_pre"});
                end
                1: begin
                    ifb.id_rs_i = {5'd4, 5'd0}; ifb.id_rs_used_i = 2'b10; ifb.flush_i = 1'b1;
                    ifb.stg_rd_i = {5'd0, 5'd0, 5'd4}; ifb.stg_regwrite_i = 3'b001; ifb.stg_memread_i = 3'b001;
                    exp_st = 1'b0; sb_q.push_back('{1, 4'b0000, "flush_in_stall"});
                end
                2: begin
                    exp_st = 1'b0; sb_q.push_back('{1, 4'b0000, "flush_back_idle"});
                end
                default: begin
                    ifa.id_rs_i = {5'd0, 5'd5}; ifa.id_rs_used_i = 2'b01; ifa.flush_i = 1'b1;
                    ifa.idexe_rd_i = 5'd5; ifa.idexe_regwrite_i = 1'b1;
                    exp_st = 1'b0; sb_q.push_back('{0, 4'b0000, "flush_over_fwd"});
                end
            endcase
            #3;
            got_st = (dut == 0) ? ifa.stall_o : ifb.stall_o;
            checks++; if (got_st !== exp_st) begin errors++; $display("FAIL flush_stall[%0d]: got %b want %b", s, got_st, exp_st); end
            tick();
            e = sb_q.pop_front();
            got = (e.dut == 0) ? ifa.fwd_sel_o : ifb.fwd_sel_o;
            checks++; if (got !== e.sel) begin errors++; $display("FAIL %s: fwd_sel=%b want %b", e.tag, got, e.sel); end
        end
    endtask

    task automatic test_reset_mid_stall();
        clear_inputs();
        ifa.id_rs_i = {5'd0, 5'd5}; ifa.id_rs_used_i = 2'b01;
        ifa.idexe_rd_i = 5'd5; ifa.idexe_regwrite_i = 1'b1;
        ifb.id_rs_i = {5'd4, 5'd0}; ifb.id_rs_used_i = 2'b10;
        ifb.idexe_rd_i = 5'd4; ifb.idexe_regwrite_i = 1'b1; ifb.idexe_memread_i = 1'b1;
        tick();
        #3;
        checks++; if (ifb.stall_o !== 1'b1) begin errors++; $display("FAIL rstmid_pre_stall: got %b want 1", ifb.stall_o); end
        checks++; if (ifa.fwd_sel_o !== 4'b0001) begin errors++; $display("FAIL rstmid_pre_sel: got %b want 0001", ifa.fwd_sel_o); end
        rst_n = 1'b0;
        #1;
        checks++; if (ifb.stall_o !== 1'b0) begin errors++; $display("FAIL rstmid_stall: got %b want 0", ifb.stall_o); end
        checks++; if (ifa.fwd_sel_o !== 4'b0000) begin errors++; $display("FAIL rstmid_sel_a: got %b want 0000", ifa.fwd_sel_o); end
        checks++; if (ifb.fwd_sel_o !== 4'b0000) begin errors++; $display("FAIL rstmid_sel_b: got %b want 0000", ifb.fwd_sel_o); end
        clear_inputs();
        #2;
        rst_n = 1'b1;
        tick();
        #3;
        checks++; if (ifb.stall_o !== 1'b0) begin errors++; $display("FAIL rstmid_post_stall: got %b want 0", ifb.stall_o); end
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_fwd_ex();
        test_youngest();
        test_load_use();
        test_load_two_cycle();
        test_zero_unused();
        test_flush();
        test_reset_mid_stall();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
